interrupt_controller: RTL and testbench

//  Sequences hardware interrupts and RTI for the 5-stage processor pipeline.

---
 rtl/interrupt_controller.sv | 166 ++++++++++++++++
 tb/tb_interrupt_controller.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_controller.sv
// ============================================================================
// Module  : interrupt_controller
// Purpose : Interrupt entry/RTI sequencer: drain, stack push/pop, vector redirect.
// Revision: 1.0
// ============================================================================
`default_nettype none

module interrupt_controller #(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        int_req,
    input  logic        rti_decoded,
    input  logic        branch_pending,
    input  logic [31:0] saved_pc,
    output logic        stall,
    output logic        if_flush,
    output logic        id_flush,
    output logic        interrupt,
    output logic        int_ret,
    output logic        int_mem_sel1,
    output logic        int_mem_sel2,
    output logic        int_mem_write,
    output logic        int_mem_read,
    output logic        int_dec_sp,
    output logic        int_inc_sp,
    output logic        restore_flags,
    output logic        int_active,
    output logic [31:0] pc_hold
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_DRAIN     = 4'd1,
        S_PUSH_HI   = 4'd2,
        S_PUSH_LO   = 4'd3,
        S_PUSH_FL   = 4'd4,
        S_VECTOR    = 4'd5,
        S_RTI_DRAIN = 4'd6,
        S_POP_FL    = 4'd7,
        S_POP_LO    = 4'd8,
        S_POP_HI    = 4'd9,
        S_RESUME    = 4'd10
    } state_t;

    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DRAIN_CYCLES - 1);

    state_t             r_state;
    state_t             w_next;
    logic               r_req_d;
    logic               r_pending;
    logic               r_active;
    logic [CNT_W-1:0]   r_cnt;
    logic [31:0]        r_pc_hold;

    logic               w_edge;
    logic               w_int_ok;
    logic               w_cnt_done;
    logic               w_in_drain;
    logic               w_enter_drain;

    assign w_edge        = int_req & ~r_req_d;
    assign w_int_ok      = r_pending & ~branch_pending & ~rti_decoded;
    assign w_cnt_done    = (r_cnt == C_CNT_LAST);
    assign w_in_drain    = (r_state == S_DRAIN) || (r_state == S_RTI_DRAIN);
    assign w_enter_drain = (w_next == S_DRAIN) && (r_state != S_DRAIN);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                // RTI wins over a waiting interrupt; nesting is blocked while active
                if (rti_decoded && r_active)
                    w_next = S_RTI_DRAIN;
                else if (w_int_ok && !r_active)
                    w_next = S_DRAIN;
            end
            S_DRAIN:     if (w_cnt_done) w_next = S_PUSH_HI;
            S_PUSH_HI:   w_next = S_PUSH_LO;
            S_PUSH_LO:   w_next = S_PUSH_FL;
            S_PUSH_FL:   w_next = S_VECTOR;
            S_VECTOR:    w_next = S_IDLE;
            S_RTI_DRAIN: if (w_cnt_done) w_next = S_POP_FL;
            S_POP_FL:    w_next = S_POP_LO;
            S_POP_LO:    w_next = S_POP_HI;
            S_POP_HI:    w_next = S_RESUME;
            // Tail-chain straight into the next drain when one is waiting
            S_RESUME:    w_next = w_int_ok ? S_DRAIN : S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            // Keep tracking the request so a level held through reset cannot re-fire
            r_req_d   <= int_req;
            r_pending <= 1'b0;
            r_active  <= 1'b0;
            r_cnt     <= '0;
            r_pc_hold <= '0;
        end else begin
            r_state   <= w_next;
            r_req_d   <= int_req;
            r_pending <= w_edge | (r_pending & (w_next != S_PUSH_HI));
            if (w_in_drain && (w_next == r_state))
                r_cnt <= r_cnt + CNT_W'(1);
            else
                r_cnt <= '0;
            if (r_state == S_VECTOR)
                r_active <= 1'b1;
            else if (r_state == S_RESUME)
                r_active <= 1'b0;
            if (w_enter_drain)
                r_pc_hold <= saved_pc;
        end
    end

    always_comb begin
        stall         = 1'b0;
        if_flush      = 1'b0;
        id_flush      = 1'b0;
        interrupt     = 1'b0;
        int_ret       = 1'b0;
        int_mem_sel1  = 1'b0;
        int_mem_sel2  = 1'b0;
        int_mem_write = 1'b0;
        int_mem_read  = 1'b0;
        int_dec_sp    = 1'b0;
        int_inc_sp    = 1'b0;
        restore_flags = 1'b0;
        case (r_state)
            S_DRAIN, S_RTI_DRAIN: begin
                stall    = 1'b1;
                if_flush = (r_cnt == '0);
                id_flush = (r_cnt == '0);
            end
            S_PUSH_HI, S_PUSH_LO, S_PUSH_FL: begin
                stall         = 1'b1;
                int_mem_write = 1'b1;
                int_dec_sp    = 1'b1;
                int_mem_sel1  = (r_state != S_PUSH_LO);
                int_mem_sel2  = (r_state != S_PUSH_HI);
            end
            S_POP_FL, S_POP_LO, S_POP_HI: begin
                stall         = 1'b1;
                int_mem_read  = 1'b1;
                int_inc_sp    = 1'b1;
                restore_flags = (r_state == S_POP_FL);
                int_mem_sel1  = (r_state != S_POP_LO);
                int_mem_sel2  = (r_state != S_POP_HI);
            end
            S_VECTOR: interrupt = 1'b1;
            S_RESUME: int_ret   = 1'b1;
            default: ;
        endcase
    end

    assign int_active = r_active;
    assign pc_hold    = r_pc_hold;

endmodule

`default_nettype wire

// File: tb/tb_interrupt_controller.sv
// ============================================================================
// Module  : tb_interrupt_controller
// Purpose : Directed cycle-by-cycle checks of the interrupt/RTI sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_interrupt_controller;

    // Observation word: {stall,if_flush,id_flush,interrupt,int_ret,sel2,sel1,
    //                    mem_write,mem_read,dec_sp,inc_sp,restore_flags,int_active}
    localparam logic [12:0] C_IDLE  = 13'h0000;
    localparam logic [12:0] C_ACT   = 13'h0001;
    localparam logic [12:0] C_DRNF  = 13'h1C00;
    localparam logic [12:0] C_DRN   = 13'h1000;
    localparam logic [12:0] C_PHI   = 13'h1068;
    localparam logic [12:0] C_PLO   = 13'h10A8;
    localparam logic [12:0] C_PFL   = 13'h10E8;
    localparam logic [12:0] C_VEC   = 13'h0200;
    localparam logic [12:0] C_RDRNF = 13'h1C01;
    localparam logic [12:0] C_RDRN  = 13'h1001;
    localparam logic [12:0] C_OFL   = 13'h10D7;
    localparam logic [12:0] C_OLO   = 13'h1095;
    localparam logic [12:0] C_OHI   = 13'h1055;
    localparam logic [12:0] C_RES   = 13'h0101;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        int_req = 1'b0;
    logic        rti_decoded = 1'b0;
    logic        branch_pending = 1'b0;
    logic [31:0] saved_pc = 32'h0;
    logic        stall, if_flush, id_flush, interrupt, int_ret;
    logic        int_mem_sel1, int_mem_sel2, int_mem_write, int_mem_read;
    logic        int_dec_sp, int_inc_sp, restore_flags, int_active;
    logic [31:0] pc_hold;
    logic [12:0] w_obs;

    int          checks = 0;
    int          errors = 0;
    int          t = 0;
    logic [12:0] trace [0:127];
    logic [12:0] exp_v [0:127];

    interrupt_controller dut (
        .clk            (clk),
        .reset          (reset),
        .int_req        (int_req),
        .rti_decoded    (rti_decoded),
        .branch_pending (branch_pending),
        .saved_pc       (saved_pc),
        .stall          (stall),
        .if_flush       (if_flush),
        .id_flush       (id_flush),
        .interrupt      (interrupt),
        .int_ret        (int_ret),
        .int_mem_sel1   (int_mem_sel1),
        .int_mem_sel2   (int_mem_sel2),
        .int_mem_write  (int_mem_write),
        .int_mem_read   (int_mem_read),
        .int_dec_sp     (int_dec_sp),
        .int_inc_sp     (int_inc_sp),
        .restore_flags  (restore_flags),
        .int_active     (int_active),
        .pc_hold        (pc_hold)
    );

    always #5 clk = ~clk;

    assign w_obs = {stall, if_flush, id_flush, interrupt, int_ret, int_mem_sel2, int_mem_sel1,
                    int_mem_write, int_mem_read, int_dec_sp, int_inc_sp, restore_flags, int_active};

    // Index t names the cycle that follows clock edge t
    task automatic tick();
        @(posedge clk);
        #1;
        t = t + 1;
        trace[t] = w_obs;
    endtask

    task automatic run_to(input int n);
        while (t < n) tick();
    endtask

    task automatic do_reset();
        int_req = 1'b0;
        rti_decoded = 1'b0;
        branch_pending = 1'b0;
        reset = 1'b1;
        t = 0;
        tick();
        tick();
        reset = 1'b0;
        t = 0;
    endtask

    task automatic test_reset();
        saved_pc = 32'hFFFF_FFFF;
        do_reset();
        checks++;
        if (w_obs !== C_IDLE) begin
            errors++;
            $display("FAIL reset_outputs got=%h exp=%h", w_obs, C_IDLE);
        end
        checks++;
        if (pc_hold !== 32'h0) begin
            errors++;
            $display("FAIL reset_pc_hold got=%h exp=%h", pc_hold, 32'h0);
        end
    endtask

    task automatic test_rti_ignored();
        do_reset();
        run_to(3);
        rti_decoded = 1'b1;
        run_to(6);
        rti_decoded = 1'b0;
        run_to(8);
        for (int i = 1; i <= 8; i++) begin
            checks++;
            if (trace[i] !== C_IDLE) begin
                errors++;
                $display("FAIL rti_ignored t=%0d got=%h exp=%h", i, trace[i], C_IDLE);
            end
        end
    endtask

    task automatic test_interrupt_entry();
        do_reset();
        saved_pc = 32'h0000_0120;
        run_to(9);
        int_req = 1'b1;
        run_to(11);
        saved_pc = 32'hDEAD_BEEF;
        run_to(12);
        int_req = 1'b0;
        run_to(20);
        for (int i = 1; i <= 20; i++) exp_v[i] = (i <= 10) ? C_IDLE : C_ACT;
        exp_v[11] = C_DRNF; exp_v[12] = C_DRN; exp_v[13] = C_DRN;
        exp_v[14] = C_PHI;  exp_v[15] = C_PLO; exp_v[16] = C_PFL; exp_v[17] = C_VEC;
        for (int i = 1; i <= 20; i++) begin
            checks++;
            if (trace[i] !== exp_v[i]) begin
                errors++;
                $display("FAIL entry t=%0d got=%h exp=%h", i, trace[i], exp_v[i]);
            end
        end
        checks++;
        if (pc_hold !== 32'h0000_0120) begin
            errors++;
            $display("FAIL entry_pc_hold got=%h exp=%h", pc_hold, 32'h0000_0120);
        end
    endtask

    task automatic test_rti();
        run_to(30);
        rti_decoded = 1'b1;
        run_to(31);
        rti_decoded = 1'b0;
        run_to(40);
        for (int i = 21; i <= 40; i++) exp_v[i] = (i <= 30) ? C_ACT : C_IDLE;
        exp_v[31] = C_RDRNF; exp_v[32] = C_RDRN; exp_v[33] = C_RDRN;
        exp_v[34] = C_OFL;   exp_v[35] = C_OLO;  exp_v[36] = C_OHI; exp_v[37] = C_RES;
        for (int i = 21; i <= 40; i++) begin
            checks++;
            if (trace[i] !== exp_v[i]) begin
                errors++;
                $display("FAIL rti t=%0d got=%h exp=%h", i, trace[i], exp_v[i]);
            end
        end
    endtask

    task automatic test_tail_chain();
        do_reset();
        saved_pc = 32'h0000_0120;
        run_to(9);
        int_req = 1'b1;
        run_to(12);
        int_req = 1'b0;
        run_to(19);
        int_req = 1'b1;
        run_to(22);
        int_req = 1'b0;
        run_to(30);
        rti_decoded = 1'b1;
        run_to(31);
        rti_decoded = 1'b0;
        run_to(35);
        saved_pc = 32'h0000_0456;
        run_to(46);
        for (int i = 1; i <= 46; i++) exp_v[i] = (i <= 10) ? C_IDLE : C_ACT;
        exp_v[11] = C_DRNF;  exp_v[12] = C_DRN;  exp_v[13] = C_DRN;
        exp_v[14] = C_PHI;   exp_v[15] = C_PLO;  exp_v[16] = C_PFL; exp_v[17] = C_VEC;
        exp_v[31] = C_RDRNF; exp_v[32] = C_RDRN; exp_v[33] = C_RDRN;
        exp_v[34] = C_OFL;   exp_v[35] = C_OLO;  exp_v[36] = C_OHI; exp_v[37] = C_RES;
        exp_v[38] = C_DRNF;  exp_v[39] = C_DRN;  exp_v[40] = C_DRN;
        exp_v[41] = C_PHI;   exp_v[42] = C_PLO;  exp_v[43] = C_PFL; exp_v[44] = C_VEC;
        for (int i = 1; i <= 46; i++) begin
            checks++;
            if (trace[i] !== exp_v[i]) begin
                errors++;
                $display("FAIL tail_chain t=%0d got=%h exp=%h", i, trace[i], exp_v[i]);
            end
        end
        checks++;
        if (pc_hold !== 32'h0000_0456) begin
            errors++;
            $display("FAIL tail_pc_hold got=%h exp=%h", pc_hold, 32'h0000_0456);
        end
    endtask

    task automatic test_branch_block();
        do_reset();
        run_to(9);
        int_req = 1'b1;
        branch_pending = 1'b1;
        run_to(14);
        branch_pending = 1'b0;
        run_to(22);
        int_req = 1'b0;
        for (int i = 1; i <= 22; i++) exp_v[i] = (i <= 14) ? C_IDLE : C_ACT;
        exp_v[15] = C_DRNF; exp_v[16] = C_DRN; exp_v[17] = C_DRN;
        exp_v[18] = C_PHI;  exp_v[19] = C_PLO; exp_v[20] = C_PFL; exp_v[21] = C_VEC;
        for (int i = 1; i <= 22; i++) begin
            checks++;
            if (trace[i] !== exp_v[i]) begin
                errors++;
                $display("FAIL branch_block t=%0d got=%h exp=%h", i, trace[i], exp_v[i]);
            end
        end
    endtask

    task automatic test_reset_mid_push();
        do_reset();
        saved_pc = 32'h0000_0120;
        run_to(9);
        int_req = 1'b1;
        run_to(15);
        checks++;
        if (trace[15] !== C_PLO) begin
            errors++;
            $display("FAIL midpush_reached got=%h exp=%h", trace[15], C_PLO);
        end
        reset = 1'b1;
        run_to(16);
        reset = 1'b0;
        checks++;
        if (pc_hold !== 32'h0) begin
            errors++;
            $display("FAIL midpush_pc_hold got=%h exp=%h", pc_hold, 32'h0);
        end
        run_to(30);
        for (int i = 16; i <= 30; i++) begin
            checks++;
            if (trace[i] !== C_IDLE) begin
                errors++;
                $display("FAIL midpush_quiet t=%0d got=%h exp=%h", i, trace[i], C_IDLE);
            end
        end
        int_req = 1'b0;
    endtask

    task automatic test_level_held();
        int n_wr = 0;
        int n_vec = 0;
        do_reset();
        run_to(9);
        int_req = 1'b1;
        run_to(59);
        int_req = 1'b0;
        run_to(70);
        for (int i = 1; i <= 70; i++) begin
            n_wr  += int'(trace[i][5]);
            n_vec += int'(trace[i][9]);
        end
        checks++;
        if (n_wr != 3) begin
            errors++;
            $display("FAIL level_pushes got=%0d exp=%0d", n_wr, 3);
        end
        checks++;
        if (n_vec != 1) begin
            errors++;
            $display("FAIL level_vectors got=%0d exp=%0d", n_vec, 1);
        end
        checks++;
        if (trace[70] !== C_ACT) begin
            errors++;
            $display("FAIL level_final got=%h exp=%h", trace[70], C_ACT);
        end
    endtask

    initial begin
        test_reset();
        test_rti_ignored();
        test_interrupt_entry();
        test_rti();
        test_tail_chain();
        test_branch_block();
        test_reset_mid_push();
        test_level_held();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
